// File: rtl/mesi_cache_agent.sv
// Per-core MESI coherence agent: turns CPU requests into ISC main-bus commands and
// answers coherence-bus snoop/enable commands from a direct-mapped line-state table.
module mesi_cache_agent #(
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned WB_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_wr_i,
  input  logic [31:0] cpu_addr_i,
  output logic        cpu_busy_o,
  output logic        cpu_done_o,
  output logic [2:0]  mbus_cmd_o,
  output logic [31:0] mbus_addr_o,
  input  logic        mbus_ack_i,
  input  logic [2:0]  cbus_cmd_i,
  input  logic [31:0] cbus_addr_i,
  output logic        cbus_ack_o,
  output logic        protocol_err_o
);
  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = 30 - IDX_W;
  localparam int unsigned CNT_W   = 4;

  localparam logic [2:0] MB_NOP = 3'd0, MB_WR = 3'd1, MB_RD = 3'd2,
                         MB_WR_BROAD = 3'd3, MB_RD_BROAD = 3'd4;
  localparam logic [2:0] CB_NOP = 3'd0, CB_WR_SNOOP = 3'd1, CB_RD_SNOOP = 3'd2,
                         CB_EN_WR = 3'd3, CB_EN_RD = 3'd4;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;

  typedef enum logic [2:0] {R_IDLE, R_BREQ, R_WAIT_EN, R_ENACK, R_MREQ} req_state_e;
  typedef enum logic [1:0] {S_IDLE, S_WB, S_ACK} snp_state_e;

  req_state_e                    req_st_q, req_st_d;
  snp_state_e                    snp_st_q, snp_st_d;
  logic [31:0]                   req_addr_q, req_addr_d;
  logic                          req_wr_q, req_wr_d;
  logic [IDX_W-1:0]              snp_idx_q, snp_idx_d;
  logic [TAG_W-1:0]              snp_tag_q, snp_tag_d;
  logic                          snp_rd_q, snp_rd_d;
  logic                          snp_err_q, snp_err_d;
  logic [CNT_W-1:0]              wb_cnt_q, wb_cnt_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][1:0]       mesi_q, mesi_d;
  logic                          cpu_busy_q, cpu_busy_d;
  logic                          cpu_done_q, cpu_done_d;
  logic [2:0]                    mbus_cmd_q, mbus_cmd_d;
  logic [31:0]                   mbus_addr_q, mbus_addr_d;
  logic                          cbus_ack_q, cbus_ack_d;
  logic                          cbus_ign_q;
  logic                          prot_err_q, prot_err_d;

  logic             cbus_live_c, is_snoop_c, en_take_c, cbus_hit_m_c, snp_hit_c;
  logic [IDX_W-1:0] cbus_idx_c, req_idx_c;
  logic [TAG_W-1:0] cbus_tag_c, req_tag_c;

  // The held command is still visible during the ack cycle and the one after it.
  assign cbus_live_c  = (cbus_cmd_i != CB_NOP) && !cbus_ack_q && !cbus_ign_q;
  assign is_snoop_c   = (cbus_cmd_i == CB_WR_SNOOP) || (cbus_cmd_i == CB_RD_SNOOP);
  assign en_take_c    = cbus_live_c && (req_st_q == R_WAIT_EN) && (cbus_addr_i == req_addr_q)
                        && (cbus_cmd_i == (req_wr_q ? CB_EN_WR : CB_EN_RD));
  assign cbus_idx_c   = cbus_addr_i[IDX_W+1:2];
  assign cbus_tag_c   = cbus_addr_i[31:IDX_W+2];
  assign cbus_hit_m_c = (mesi_q[cbus_idx_c] == ST_M) && (tag_q[cbus_idx_c] == cbus_tag_c);
  assign snp_hit_c    = (mesi_q[snp_idx_q] != ST_I) && (tag_q[snp_idx_q] == snp_tag_q);
  assign req_idx_c    = req_addr_q[IDX_W+1:2];
  assign req_tag_c    = req_addr_q[31:IDX_W+2];

  // State register, captured data, line table and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_st_q    <= R_IDLE;
      snp_st_q    <= S_IDLE;
      req_addr_q  <= '0;
      req_wr_q    <= 1'b0;
      snp_idx_q   <= '0;
      snp_tag_q   <= '0;
      snp_rd_q    <= 1'b0;
      snp_err_q   <= 1'b0;
      wb_cnt_q    <= '0;
      tag_q       <= '0;
      mesi_q      <= {ENTRIES{ST_I}};
      cpu_busy_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
      mbus_cmd_q  <= MB_NOP;
      mbus_addr_q <= '0;
      cbus_ack_q  <= 1'b0;
      cbus_ign_q  <= 1'b0;
      prot_err_q  <= 1'b0;
    end else begin
      req_st_q    <= req_st_d;
      snp_st_q    <= snp_st_d;
      req_addr_q  <= req_addr_d;
      req_wr_q    <= req_wr_d;
      snp_idx_q   <= snp_idx_d;
      snp_tag_q   <= snp_tag_d;
      snp_rd_q    <= snp_rd_d;
      snp_err_q   <= snp_err_d;
      wb_cnt_q    <= wb_cnt_d;
      tag_q       <= tag_d;
      mesi_q      <= mesi_d;
      cpu_busy_q  <= cpu_busy_d;
      cpu_done_q  <= cpu_done_d;
      mbus_cmd_q  <= mbus_cmd_d;
      mbus_addr_q <= mbus_addr_d;
      cbus_ack_q  <= cbus_ack_d;
      cbus_ign_q  <= cbus_ack_q;
      prot_err_q  <= prot_err_d;
    end
  end

  // Next state for both FSMs; EN commands not taken by the request side go to the snoop side
  always_comb begin
    req_st_d   = req_st_q;
    req_addr_d = req_addr_q;
    req_wr_d   = req_wr_q;
    snp_st_d   = snp_st_q;
    snp_idx_d  = snp_idx_q;
    snp_tag_d  = snp_tag_q;
    snp_rd_d   = snp_rd_q;
    snp_err_d  = snp_err_q;
    wb_cnt_d   = wb_cnt_q;
    case (req_st_q)
      R_IDLE: if (cpu_req_i) begin
        req_addr_d = cpu_addr_i;
        req_wr_d   = cpu_wr_i;
        req_st_d   = R_BREQ;
      end
      R_BREQ:    if (mbus_ack_i) req_st_d = R_WAIT_EN;
      R_WAIT_EN: if (en_take_c) req_st_d = R_ENACK;
      R_ENACK:   req_st_d = R_MREQ;
      R_MREQ:    if (mbus_ack_i) req_st_d = R_IDLE;
      default:   req_st_d = R_IDLE;
    endcase
    case (snp_st_q)
      S_IDLE: if (cbus_live_c && !en_take_c) begin
        snp_idx_d = cbus_idx_c;
        snp_tag_d = cbus_tag_c;
        snp_rd_d  = (cbus_cmd_i == CB_RD_SNOOP);
        snp_err_d = !is_snoop_c;
        wb_cnt_d  = CNT_W'(WB_LAT) - CNT_W'(1);
        if (is_snoop_c && cbus_hit_m_c && (WB_LAT != 0)) snp_st_d = S_WB;
        else snp_st_d = S_ACK;
      end
      S_WB: begin
        if (wb_cnt_q == '0) snp_st_d = S_ACK;
        else wb_cnt_d = wb_cnt_q - CNT_W'(1);
      end
      S_ACK:   snp_st_d = S_IDLE;
      default: snp_st_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    cpu_busy_d = (req_st_d != R_IDLE);
    cpu_done_d = (req_st_q == R_MREQ) && mbus_ack_i;
    mbus_cmd_d = MB_NOP;
    if (req_st_d == R_BREQ) mbus_cmd_d = req_wr_d ? MB_WR_BROAD : MB_RD_BROAD;
    else if (req_st_d == R_MREQ) mbus_cmd_d = req_wr_d ? MB_WR : MB_RD;
    mbus_addr_d = (mbus_cmd_d != MB_NOP) ? req_addr_d : '0;
    cbus_ack_d  = (req_st_d == R_ENACK) || (snp_st_d == S_ACK);
    prot_err_d  = (snp_st_d == S_ACK) && snp_err_d;
  end

  // Line table: snoop downgrade at ack, own completion installs last so it wins
  always_comb begin
    tag_d  = tag_q;
    mesi_d = mesi_q;
    if ((snp_st_q == S_ACK) && !snp_err_q && snp_hit_c) begin
      if (!snp_rd_q) mesi_d[snp_idx_q] = ST_I;
      else if ((mesi_q[snp_idx_q] == ST_M) || (mesi_q[snp_idx_q] == ST_E)) mesi_d[snp_idx_q] = ST_S;
    end
    if (cpu_done_d) begin
      tag_d[req_idx_c]  = req_tag_c;
      mesi_d[req_idx_c] = req_wr_q ? ST_M : ST_S;
    end
  end

  assign cpu_busy_o     = cpu_busy_q;
  assign cpu_done_o     = cpu_done_q;
  assign mbus_cmd_o     = mbus_cmd_q;
  assign mbus_addr_o    = mbus_addr_q;
  assign cbus_ack_o     = cbus_ack_q;
  assign protocol_err_o = prot_err_q;

endmodule

// File: tb/tb_mesi_cache_agent.sv
// Bench for mesi_cache_agent: directed scenarios plus randomized traffic checked against
// a line-level MESI model (only M vs not-M is visible, through snoop ack latency).
module tb_mesi_cache_agent;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned WB_LAT = 3;
  localparam int unsigned LINES  = 4;
  localparam int M_I = 0, M_S = 1, M_M = 3;
  localparam logic [2:0] WR_SNOOP = 3'd1, RD_SNOOP = 3'd2, EN_WR = 3'd3, EN_RD = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, cpu_busy, cpu_done;
  logic [31:0] cpu_addr;
  logic [2:0]  mbus_cmd;
  logic [31:0] mbus_addr;
  logic        mbus_ack;
  logic [2:0]  cbus_cmd;
  logic [31:0] cbus_addr;
  logic        cbus_ack, perr;

  int          n_checks = 0;
  int          n_err = 0;
  int          m_state [LINES];
  logic [29:0] m_line [LINES];
  logic [31:0] pool [6] = '{32'h100, 32'h200, 32'h104, 32'h80, 32'h48, 32'h10C};

  mesi_cache_agent #(.IDX_W(IDX_W), .WB_LAT(WB_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr),
    .cpu_busy_o(cpu_busy), .cpu_done_o(cpu_done),
    .mbus_cmd_o(mbus_cmd), .mbus_addr_o(mbus_addr), .mbus_ack_i(mbus_ack),
    .cbus_cmd_i(cbus_cmd), .cbus_addr_i(cbus_addr),
    .cbus_ack_o(cbus_ack), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(LINES); i++) begin
      m_state[i] = M_I;
      m_line[i]  = '0;
    end
  endtask

  // Snoop: expected ack latency from the model, then apply the MESI rule to the model.
  task automatic snoop(input logic [2:0] cmd, input logic [31:0] addr);
    int  i, lat, exp_lat;
    bit  hit;
    i       = line_of(addr);
    hit     = (m_state[i] != M_I) && (m_line[i] == addr[31:2]);
    exp_lat = (hit && m_state[i] == M_M) ? 1 + int'(WB_LAT) : 1;
    cbus_cmd = cmd; cbus_addr = addr; lat = 0;
    do begin
      tick();
      lat++;
    end while (!cbus_ack && lat < 40);
    cbus_cmd = 3'd0;
    chk("snoop_latency", 32'(lat), 32'(exp_lat));
    chk("snoop_no_err", 32'(perr), 32'd0);
    if (hit) begin
      if (cmd == WR_SNOOP) m_state[i] = M_I;
      else if (m_state[i] == M_M) m_state[i] = M_S;
    end
    tick();
    chk("snoop_ack_pulse", 32'(cbus_ack), 32'd0);
    tick();
  endtask

  // Unexpected EN or illegal encoding: acked next cycle with a protocol error pulse.
  task automatic en_err(input logic [2:0] cmd, input logic [31:0] addr, input logic exp_busy);
    cbus_cmd = cmd; cbus_addr = addr;
    tick();
    cbus_cmd = 3'd0;
    chk("err_ack", 32'(cbus_ack), 32'd1);
    chk("err_flag", 32'(perr), 32'd1);
    chk("err_busy", 32'(cpu_busy), 32'(exp_busy));
    chk("err_mbus_nop", 32'(mbus_cmd), 32'd0);
    tick();
    chk("err_ack_pulse", 32'(cbus_ack), 32'd0);
    chk("err_flag_pulse", 32'(perr), 32'd0);
    tick();
  endtask

  // Full CPU transaction; mode 1 injects a snoop and mode 2 a wrong EN while waiting for EN.
  task automatic cpu_txn(input logic wr, input logic [31:0] addr, input int d_back, input int d_en,
                         input int d_mem, input int mode, input logic [2:0] x_cmd,
                         input logic [31:0] x_addr);
    logic [31:0] bc, mc;
    int          i;
    bc = wr ? 32'd3 : 32'd4;
    mc = wr ? 32'd1 : 32'd2;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr;
    tick();
    cpu_req = 1'b0;
    chk("bcast_cmd", 32'(mbus_cmd), bc);
    chk("bcast_addr", mbus_addr, addr);
    chk("busy_set", 32'(cpu_busy), 32'd1);
    for (int k = 0; k < d_back; k++) begin
      cpu_req = 1'($urandom); cpu_wr = 1'($urandom); cpu_addr = $urandom;
      tick();
      chk("bcast_hold", 32'(mbus_cmd), bc);
    end
    cpu_req = 1'b0; mbus_ack = 1'b1;
    tick();
    mbus_ack = 1'b0;
    chk("bcast_drop", 32'(mbus_cmd), 32'd0);
    chk("wait_busy", 32'(cpu_busy), 32'd1);
    for (int k = 0; k < d_en; k++) begin
      mbus_ack = 1'($urandom); cpu_req = 1'($urandom); cpu_addr = $urandom;
      tick();
      chk("wait_nop", 32'(mbus_cmd), 32'd0);
    end
    mbus_ack = 1'b0; cpu_req = 1'b0;
    if (mode == 1) snoop(x_cmd, x_addr);
    else if (mode == 2) en_err(x_cmd, x_addr, 1'b1);
    cbus_cmd = wr ? EN_WR : EN_RD; cbus_addr = addr;
    tick();
    cbus_cmd = 3'd0;
    chk("en_ack", 32'(cbus_ack), 32'd1);
    chk("en_no_err", 32'(perr), 32'd0);
    chk("enack_nop", 32'(mbus_cmd), 32'd0);
    tick();
    chk("mem_cmd", 32'(mbus_cmd), mc);
    chk("mem_addr", mbus_addr, addr);
    chk("en_ack_pulse", 32'(cbus_ack), 32'd0);
    for (int k = 0; k < d_mem; k++) begin
      tick();
      chk("mem_hold", 32'(mbus_cmd), mc);
      chk("done_early", 32'(cpu_done), 32'd0);
    end
    mbus_ack = 1'b1;
    tick();
    mbus_ack = 1'b0;
    chk("done", 32'(cpu_done), 32'd1);
    chk("busy_clr", 32'(cpu_busy), 32'd0);
    chk("mem_drop", 32'(mbus_cmd), 32'd0);
    i = line_of(addr);
    m_state[i] = wr ? M_M : M_S;
    m_line[i]  = addr[31:2];
    tick();
    chk("done_pulse", 32'(cpu_done), 32'd0);
  endtask

  initial begin
    logic [31:0] a, xa;
    logic [2:0]  xc;
    logic        w;
    int          op, mode;
    rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    mbus_ack = 1'b0; cbus_cmd = 3'd0; cbus_addr = '0;
    model_clear();
    repeat (3) tick();
    chk("rst_cmd", 32'(mbus_cmd), 32'd0);
    chk("rst_addr", mbus_addr, 32'd0);
    chk("rst_busy", 32'(cpu_busy), 32'd0);
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_ack", 32'(cbus_ack), 32'd0);
    chk("rst_err", 32'(perr), 32'd0);
    rst = 1'b0;
    tick();

    // Write 0x100 with the reference timeline, then snoop it down to S and I
    cpu_txn(1'b1, 32'h100, 2, 2, 1, 0, 3'd0, 32'h0);
    repeat (8) tick();
    snoop(RD_SNOOP, 32'h100);
    snoop(WR_SNOOP, 32'h100);
    snoop(WR_SNOOP, 32'h200);

    // Unexpected EN while idle, and illegal encodings
    en_err(EN_RD, 32'h40, 1'b0);
    for (int c = 5; c < 8; c++) en_err(3'(c), 32'h40, 1'b0);

    // Read 0x80 with a same-address write snoop arriving before its EN
    cpu_txn(1'b0, 32'h80, 1, 1, 0, 1, WR_SNOOP, 32'h80);
    snoop(RD_SNOOP, 32'h80);
    // Wrong-direction EN during WAIT_EN is rejected without disturbing the request
    cpu_txn(1'b1, 32'h48, 0, 1, 2, 2, EN_RD, 32'h48);
    snoop(RD_SNOOP, 32'h48);

    // Reset during MREQ, with the memory ack in the same cycle
    cpu_txn(1'b1, 32'h300, 0, 0, 0, 0, 3'd0, 32'h0);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h104;
    tick();
    cpu_req = 1'b0; mbus_ack = 1'b1;
    tick();
    mbus_ack = 1'b0; cbus_cmd = EN_WR; cbus_addr = 32'h104;
    tick();
    cbus_cmd = 3'd0;
    tick();
    chk("pre_rst_mreq", 32'(mbus_cmd), 32'd1);
    rst = 1'b1; mbus_ack = 1'b1;
    tick();
    rst = 1'b0; mbus_ack = 1'b0;
    chk("mrst_cmd", 32'(mbus_cmd), 32'd0);
    chk("mrst_addr", mbus_addr, 32'd0);
    chk("mrst_busy", 32'(cpu_busy), 32'd0);
    chk("mrst_done", 32'(cpu_done), 32'd0);
    chk("mrst_ack", 32'(cbus_ack), 32'd0);
    chk("mrst_err", 32'(perr), 32'd0);
    tick();
    chk("mrst_no_done", 32'(cpu_done), 32'd0);
    model_clear();
    snoop(RD_SNOOP, 32'h300);
    snoop(RD_SNOOP, 32'h104);
    cpu_txn(1'b1, 32'h100, 2, 2, 1, 0, 3'd0, 32'h0);
    snoop(RD_SNOOP, 32'h100);

    // Randomized traffic over a small address pool so lines collide
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(3);
      a  = pool[$urandom_range(5)];
      w  = 1'($urandom);
      if (op <= 1) begin
        mode = $urandom_range(2);
        xc   = w ? EN_RD : EN_WR;
        xa   = a;
        if (mode == 1) begin
          xc = $urandom_range(1) != 0 ? WR_SNOOP : RD_SNOOP;
          xa = pool[$urandom_range(5)];
        end else if (mode == 2 && $urandom_range(1) != 0) begin
          xc = w ? EN_WR : EN_RD;
          xa = a ^ 32'h40;
        end
        cpu_txn(w, a, $urandom_range(3), $urandom_range(3), $urandom_range(3), mode, xc, xa);
      end else if (op == 2) begin
        snoop($urandom_range(1) != 0 ? WR_SNOOP : RD_SNOOP, a);
      end else begin
        xc = 3'($urandom_range(7, 3));
        en_err(xc, a, 1'b0);
      end
      for (int k = 0; k < int'($urandom_range(2)); k++) begin
        mbus_ack = 1'($urandom);
        tick();
        chk("idle_nop", 32'(mbus_cmd), 32'd0);
        chk("idle_busy", 32'(cpu_busy), 32'd0);
      end
      mbus_ack = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
